// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants for the raster timing generator: default 640x480@60
// region lengths, line/frame totals, coordinate width and the
// out-of-active-area coordinate marker.
package vga_timing_pkg;

    localparam int COORD_W = 14;
    localparam logic [COORD_W-1:0] COORD_INVALID = 14'h3FFF;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Length of one axis period: active + front porch + sync + back porch.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if
// Raster timing bundle between the timing generator (master) and the
// pixel data stage vga_data (slave).
//   hsync, vsync   sync pulses at the configured polarity
//   de             data enable, high in the active area
//   pix_x, pix_y   active-area coordinates, COORD_INVALID elsewhere
//   frame_start    one-cycle pulse with pixel (0,0)
//   frame_cnt      completed frames, wrapping
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               frame_start;
    logic [7:0]         frame_cnt;

    modport master (
        output hsync, vsync, de, pix_x, pix_y, frame_start, frame_cnt
    );

    modport slave (
        input hsync, vsync, de, pix_x, pix_y, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: counts 0..TOTAL-1 on each inc and wraps, decoding the
// active and sync regions (order: active, front porch, sync, back porch).
//   clk, rst  pixel clock, asynchronous active-high reset
//   inc       advance by one
//   cnt       current position
//   wrap      position is the last of the period (next inc returns to 0)
//   active    position is inside the active region
//   sync      position is inside the sync pulse
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               active,
    output logic               sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] cnt_r;

    // Position counter, wraps after the back porch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 14'd0;
        end else if (inc) begin
            if (cnt_r == LAST) begin
                cnt_r <= 14'd0;
            end else begin
                cnt_r <= cnt_r + 14'd1;
            end
        end
    end

    assign cnt    = cnt_r;
    assign wrap   = (cnt_r == LAST);
    assign active = (cnt_r < ACT_END);
    assign sync   = (cnt_r >= SYNC_START) && (cnt_r < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator: horizontal/vertical counters plus registered
// sync, data-enable, coordinate and frame outputs.
//   clk  pixel clock
//   rst  asynchronous active-high reset
//   en   count enable; low freezes counters and outputs
//   vid  vga_timing_if master: hsync, vsync, de, pix_x, pix_y,
//        frame_start, frame_cnt
// Build option VGA_TIMING_PREFETCH_EN: hsync/vsync/de/frame_start get one
// extra register stage so that pix_x/pix_y lead them by one cycle, which
// covers the image ROM read latency in vga_data.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_timing_if.master vid
);

    logic [COORD_W-1:0] h_cnt_s, v_cnt_s;
    logic               h_wrap_s, v_wrap_s, h_active_s, v_active_s;
    logic               h_sync_s, v_sync_s, v_inc_s;
    logic               de_s, fs_s, hsync_s, vsync_s;
    logic [COORD_W-1:0] pix_x_s, pix_y_s;

    logic               hsync_r, vsync_r, de_r, fs_r;
    logic [COORD_W-1:0] pix_x_r, pix_y_r;
    logic [7:0]         frame_cnt_r;

    assign v_inc_s = h_wrap_s & en;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_cnt (
        .clk(clk), .rst(rst), .inc(en),
        .cnt(h_cnt_s), .wrap(h_wrap_s), .active(h_active_s), .sync(h_sync_s)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_cnt (
        .clk(clk), .rst(rst), .inc(v_inc_s),
        .cnt(v_cnt_s), .wrap(v_wrap_s), .active(v_active_s), .sync(v_sync_s)
    );

    // Decode of the current counter state into raw output values.
    always_comb begin
        de_s    = h_active_s & v_active_s;
        fs_s    = (h_cnt_s == 14'd0) && (v_cnt_s == 14'd0);
        hsync_s = h_sync_s ? SYNC_POL : ~SYNC_POL;
        vsync_s = v_sync_s ? SYNC_POL : ~SYNC_POL;
        pix_x_s = COORD_INVALID;
        pix_y_s = COORD_INVALID;
        if (de_s) begin
            pix_x_s = h_cnt_s;
            pix_y_s = v_cnt_s;
        end else begin
            pix_x_s = COORD_INVALID;
            pix_y_s = COORD_INVALID;
        end
    end

    // First output stage: registers the decode, holds while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r <= ~SYNC_POL;
            vsync_r <= ~SYNC_POL;
            de_r    <= 1'b0;
            pix_x_r <= COORD_INVALID;
            pix_y_r <= COORD_INVALID;
        end else if (en) begin
            hsync_r <= hsync_s;
            vsync_r <= vsync_s;
            de_r    <= de_s;
            pix_x_r <= pix_x_s;
            pix_y_r <= pix_y_s;
        end
    end

    // Frame-start stage: when it drives the output it drops to 0 on a stall,
    // when it feeds the delay stage it must hold so the pulse is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_r <= 1'b0;
        end else if (en) begin
            fs_r <= fs_s;
        end else begin
`ifdef VGA_TIMING_PREFETCH_EN
            fs_r <= fs_r;
`else
            fs_r <= 1'b0;
`endif
        end
    end

    // Completed-frame counter, steps when both axes wrap on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 8'd0;
        end else if (en && h_wrap_s && v_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end
    end

`ifdef VGA_TIMING_PREFETCH_EN
    logic hsync_d_r, vsync_d_r, de_d_r, fs_d_r;

    // Delay stage for the timing strobes; coordinates bypass it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_d_r <= ~SYNC_POL;
            vsync_d_r <= ~SYNC_POL;
            de_d_r    <= 1'b0;
            fs_d_r    <= 1'b0;
        end else if (en) begin
            hsync_d_r <= hsync_r;
            vsync_d_r <= vsync_r;
            de_d_r    <= de_r;
            fs_d_r    <= fs_r;
        end else begin
            fs_d_r    <= 1'b0;
        end
    end

    assign vid.hsync       = hsync_d_r;
    assign vid.vsync       = vsync_d_r;
    assign vid.de          = de_d_r;
    assign vid.frame_start = fs_d_r;
`else
    assign vid.hsync       = hsync_r;
    assign vid.vsync       = vsync_r;
    assign vid.de          = de_r;
    assign vid.frame_start = fs_r;
`endif

    assign vid.pix_x     = pix_x_r;
    assign vid.pix_y     = pix_y_r;
    assign vid.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Horizontal timing uses the
// 640x480 defaults; the vertical axis is shortened (20+3+2+5 = 30 lines)
// so a whole frame (24000 cycles) fits in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int VA = 20, VF = 3, VS = 2, VB = 5;
    localparam int FRAME = H_TOTAL_DEF * (VA + VF + VS + VB);
`ifdef VGA_TIMING_PREFETCH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vga_timing_if vid();

    vga_timing_gen #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .vid(vid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [13:0] x;
        logic [13:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the given coordinate is shown or the budget runs out.
    task automatic wait_xy(input logic [13:0] x, input logic [13:0] y,
                           input int budget, output int cnt);
        cnt = 0;
        while (!(vid.pix_x == x && vid.pix_y == y) && cnt < budget) begin
            tick();
            cnt++;
        end
        chk("wait_xy_reached", {31'd0, (vid.pix_x == x && vid.pix_y == y)}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pix_x"}, vid.pix_x, COORD_INVALID);
        chk({tag, "_pix_y"}, vid.pix_y, COORD_INVALID);
        chk({tag, "_de"}, vid.de, 1'b0);
        chk({tag, "_hsync"}, vid.hsync, 1'b1);
        chk({tag, "_vsync"}, vid.vsync, 1'b1);
        chk({tag, "_fs"}, vid.frame_start, 1'b0);
        chk({tag, "_fcnt"}, vid.frame_cnt, 8'd0);
    endtask

    initial begin
        logic [13:0] inv;
        int c, tot;
        inv = COORD_INVALID;

        vecs[0]  = '{1,     14'd0,   14'd0,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{2,     14'd1,   14'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{640,   14'd639, 14'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{641,   inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{656,   inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{657,   inv,     inv,    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{752,   inv,     inv,    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{753,   inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{800,   inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{801,   14'd0,   14'd1,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{15840, 14'd639, 14'd19, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16001, inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{18400, inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{18401, inv,     inv,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{19057, inv,     inv,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{20000, inv,     inv,    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{20001, inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{24000, inv,     inv,    1'b0, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{24001, 14'd0,   14'd0,  1'b1, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{24002, 14'd1,   14'd0,  1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state.
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;

        // Free-running raster from reset release, one full frame plus two cycles.
        for (int cyc = 1; cyc <= FRAME + 2 + LAT; cyc++) begin
            tick();
            for (int i = 0; i < 20; i++) begin
                if (vecs[i].n == cyc) begin
                    chk($sformatf("v%0d_pix_x", vecs[i].n), vid.pix_x, vecs[i].x);
                    chk($sformatf("v%0d_pix_y", vecs[i].n), vid.pix_y, vecs[i].y);
                end
                if (vecs[i].n + LAT == cyc) begin
                    chk($sformatf("v%0d_de", vecs[i].n), vid.de, vecs[i].de);
                    chk($sformatf("v%0d_hsync", vecs[i].n), vid.hsync, vecs[i].hs);
                    chk($sformatf("v%0d_vsync", vecs[i].n), vid.vsync, vecs[i].vs);
                    chk($sformatf("v%0d_fs", vecs[i].n), vid.frame_start, vecs[i].fs);
                end
            end
            if (cyc == FRAME - 1) chk("fcnt_before_wrap", vid.frame_cnt, 8'd0);
            if (cyc == FRAME + 1) chk("fcnt_after_frame", vid.frame_cnt, 8'd1);
        end

        // Stall for 10 cycles at pix_x=100 on line 1: line stretches to 810.
        wait_xy(14'd0, 14'd1, 2000, c);
        wait_xy(14'd100, 14'd1, 200, c);
        chk("stall_reach_100", c, 100);
        tot = c;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_pix_x", vid.pix_x, 14'd100);
            chk("stall_de", vid.de, 1'b1);
            chk("stall_fs", vid.frame_start, 1'b0);
        end
        tot += 10;
        en = 1'b1;
        tick();
        chk("resume_pix_x", vid.pix_x, 14'd101);
        chk("resume_pix_y", vid.pix_y, 14'd1);
        tot += 1;
        wait_xy(14'd0, 14'd2, 1000, c);
        tot += c;
        chk("stretched_line_period", tot, 810);

        // Asynchronous reset mid-frame, then restart at (0,0).
        wait_xy(14'd300, 14'd10, 10000, c);
        chk("pre_reset_fcnt", vid.frame_cnt, 8'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        en  = 1'b0;
        tick();
        chk_reset_vals("post_rst_stall");
        en = 1'b1;
        tick();
        chk("restart_pix_x", vid.pix_x, 14'd0);
        chk("restart_pix_y", vid.pix_y, 14'd0);
`ifdef VGA_TIMING_PREFETCH_EN
        chk("restart_de_lag", vid.de, 1'b0);
        chk("restart_fs_lag", vid.frame_start, 1'b0);
        en = 1'b0;
        tick();
        chk("hold_pix_x", vid.pix_x, 14'd0);
        chk("hold_fs", vid.frame_start, 1'b0);
        en = 1'b1;
        tick();
        chk("pf_pix_x", vid.pix_x, 14'd1);
        chk("pf_de", vid.de, 1'b1);
        chk("pf_fs", vid.frame_start, 1'b1);
        tick();
        chk("pf_fs_end", vid.frame_start, 1'b0);
`else
        chk("restart_de", vid.de, 1'b1);
        chk("restart_fs", vid.frame_start, 1'b1);
        en = 1'b0;
        tick();
        chk("hold_pix_x", vid.pix_x, 14'd0);
        chk("hold_de", vid.de, 1'b1);
        chk("hold_fs_forced_low", vid.frame_start, 1'b0);
        en = 1'b1;
        tick();
        chk("after_hold_pix_x", vid.pix_x, 14'd1);
        chk("after_hold_fs", vid.frame_start, 1'b0);
`endif
        chk("restart_fcnt", vid.frame_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the HDMI/VGA display path. Counts horizontal and vertical positions over a parameterised 640x480@60 raster and drives hsync, vsync and data-enable. Emits the pixel coordinates `pix_x`/`pix_y` consumed by `vga_data`, which turns them into an image ROM address. It is the coordinate source for that interface; `vga_data` is the sink.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: sync asserted level; 0 = active-low
- `clk`  in  1  pixel clock
- `rst`  in  1  reset; one clock, asynchronous and active-high
- `en`  in  1  count enable; low freezes counters and all outputs
- `hsync`  out  1  horizontal sync at `SYNC_POL`
- `vsync`  out  1  vertical sync at `SYNC_POL`
- `de`  out  1  high while in the active area
- `pix_x`  out  14  column 0..H_ACTIVE-1; 14'h3FFF outside the active area
- `pix_y`  out  14  row 0..V_ACTIVE-1; 14'h3FFF outside the active area
- `frame_start`  out  1  one-cycle pulse when the (0,0) pixel is presented
- `frame_cnt`  out  8  frames completed, wraps 255→0

## Operation
- `H_TOTAL` = sum of the H parameters = 800; `V_TOTAL` = sum of the V parameters = 525.
- Horizontal counter `h_cnt` counts 0..H_TOTAL-1 and wraps to 0.
- Vertical counter `v_cnt` advances only on the `h_cnt` wrap. It counts 0..V_TOTAL-1 and wraps to 0.
- Region order on each axis: active, front porch, sync, back porch.
- Sync is asserted for counts [ACTIVE+FP, ACTIVE+FP+SYNC). For defaults: hsync at `h_cnt` 656..751, vsync at `v_cnt` 490..491.
- `de` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- `pix_x` = `h_cnt` and `pix_y` = `v_cnt` when `de` is high; otherwise both are 14'h3FFF.
- `frame_start` is the decode of `h_cnt`==0 && `v_cnt`==0.
- `frame_cnt` increments when both counters wrap together.
- When `en` is low, counters, output registers and the prefetch stage all hold. `frame_start` is forced to 0 while `en` is low, so it never stretches.

## Timing
- All outputs are registered. Outputs in cycle k+1 reflect the counter state in cycle k with `en` high: one cycle of latency.
- Reset values:
  - `h_cnt` = `v_cnt` = 0
  - `hsync` = `vsync` = ~SYNC_POL
  - `de` = 0, `frame_start` = 0, `frame_cnt` = 0
  - `pix_x` = `pix_y` = 14'h3FFF
- First enabled edge after `rst` deasserts: outputs present (0,0), `de` = 1, `frame_start` = 1.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). The raster restarts at (0,0) and no partial-frame pulse is produced.
- Line wrap on the last line (`h_cnt`=799, `v_cnt`=524): both counters go to 0 on the same edge.
- Frame period at defaults: 420000 enabled cycles.

## Configuration
- Macro: `VGA_TIMING_PREFETCH_EN`.
- Defined:
  - `hsync`, `vsync`, `de` and `frame_start` pass through one extra register stage, which also stalls on `en` low.
  - `pix_x`/`pix_y` therefore lead `de` by exactly one cycle. This hides the one-cycle ROM read latency behind `vga_data`.
  - Reset values are unchanged.
- Undefined:
  - All outputs are decoded from the same counter state and are cycle-aligned.

## Structure
- Package `vga_timing_pkg`:
  - default 640x480 timing constants
  - `H_TOTAL`/`V_TOTAL` derivation
  - the 14'h3FFF invalid-coordinate constant
  - coordinate width (14)
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - parameterised by the four region lengths
  - inputs: `clk`, `rst`, `inc`
  - outputs: `cnt`, `wrap`, `active`, `sync`
  - the vertical instance's `inc` is the horizontal instance's `wrap` gated by `en`

## Test plan
- Reset with `en`=1, release → first output cycle shows `pix_x`=0, `pix_y`=0, `de`=1, `frame_start`=1. Next 639 cycles show `pix_x` 1..639, then `pix_x`=14'h3FFF and `de`=0 for 160 cycles.
- Line 0 → `hsync` low exactly 96 cycles, beginning 656 cycles after `pix_x`=0. `de` high exactly 640 cycles per line.
- Full frame → `vsync` low during lines 490–491 only. `frame_start` pulses again after 420000 cycles. `frame_cnt` = 1.
- Drop `en` for 10 cycles at `pix_x`=100 → all outputs frozen at `pix_x`=100. Sequence resumes with 101 and the line period stretches to 810 cycles.
- Assert `rst` at `pix_x`=300, `pix_y`=200 → outputs take reset values within the same cycle. After release the raster restarts at (0,0) and `frame_cnt`=0.
- Build with `VGA_TIMING_PREFETCH_EN` → `pix_x`=0 appears one cycle before `de` rises. The last visible cycle has `de`=1 while `pix_x`=14'h3FFF.
